// File: rtl/jtkiwi_shram.sv
// Shared 8 KB RAM between the Kiwi main and sub CPUs.
// Two single-byte request ports, each with an ok strobe that releases the CPU wait state.
//
// Ports:
//   rst, clk          - async active-high reset, 24 MHz CPU clock
//   main_cs/addr/we/din -> main_dout/main_ok : main CPU port
//   sub_cs/addr/we/din  -> sub_dout/sub_ok   : sub CPU port
// Parameters:
//   AW      - address width, RAM depth is 2^AW bytes
//   SIMFILE - kept for drop-in compatibility; this model does no preload
module jtkiwi_shram #(
  parameter int AW      = 13,
  parameter     SIMFILE = ""
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          main_cs,
  input  logic [AW-1:0] main_addr,
  input  logic          main_we,
  input  logic [7:0]    main_din,
  output logic [7:0]    main_dout,
  output logic          main_ok,
  input  logic          sub_cs,
  input  logic [AW-1:0] sub_addr,
  input  logic          sub_we,
  input  logic [7:0]    sub_din,
  output logic [7:0]    sub_dout,
  output logic          sub_ok
);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t        r_state;
  logic          r_lg_sub;
  logic          r_gsub;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [7:0]    r_din;

  logic [7:0] r_mem [0:(1<<AW)-1];

  logic       w_mpend;
  logic       w_spend;
  logic       w_gsub;
  logic       w_acc;
  logic [7:0] w_rd;

  // A port with ok already high is not pending: a held cs never retriggers.
  assign w_mpend = main_cs & ~main_ok;
  assign w_spend = sub_cs & ~sub_ok;
  // On a tie, sub wins only if main was granted last.
  assign w_gsub  = w_spend & (~w_mpend | ~r_lg_sub);
  assign w_acc   = (r_state == ACC);
  assign w_rd    = r_mem[r_addr];

  // Reset forces IDLE asynchronously, so an interrupted write never lands.
  always_ff @(posedge clk) begin
    if (w_acc && r_we)
      r_mem[r_addr] <= r_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lg_sub  <= 1'b1;
      r_gsub    <= 1'b0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_din     <= 8'd0;
      main_ok   <= 1'b0;
      sub_ok    <= 1'b0;
      main_dout <= 8'd0;
      sub_dout  <= 8'd0;
    end else begin
      if (!main_cs) main_ok <= 1'b0;
      if (!sub_cs)  sub_ok  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_mpend || w_spend) begin
            r_gsub   <= w_gsub;
            r_lg_sub <= w_gsub;
            r_addr   <= w_gsub ? sub_addr : main_addr;
            r_we     <= w_gsub ? sub_we   : main_we;
            r_din    <= w_gsub ? sub_din  : main_din;
            r_state  <= ACC;
          end
        end
        ACC: begin
          // ok set here overrides a cs drop seen on this same edge.
          if (r_gsub) begin
            sub_ok   <= 1'b1;
            sub_dout <= r_we ? r_din : w_rd;
          end else begin
            main_ok   <= 1'b1;
            main_dout <= r_we ? r_din : w_rd;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
